// File: rtl/depth_clear_sequencer.sv
// Depth buffer clear initiator.
// It holds off rasterizer depth writes and drains the in-flight depth pipeline.
// It then strobes clear_req over every depth-buffer address, one address per cycle,
// and pulses done once when the sweep is finished.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for clear_start; depth writes pass straight through
// DRAIN | writes held off while the in-flight depth pipeline empties
// CLEAR | clear_req asserted, clear_addr walks 0 .. N-1
// DONE  | single-cycle done pulse, rasterizer still stalled
module depth_clear_sequencer #(
  parameter int BUFFER_WIDTH      = 160,
  parameter int BUFFER_HEIGHT     = 120,
  parameter int BUFFER_ADDR_WIDTH = $clog2(BUFFER_WIDTH * BUFFER_HEIGHT),
  parameter int DRAIN_CYCLES      = 2
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         clear_start,
  input  logic                         write_req_in,
  output logic                         write_req_out,
  output logic                         raster_stall,
  output logic                         clear_req,
  output logic [BUFFER_ADDR_WIDTH-1:0] clear_addr,
  output logic                         busy,
  output logic                         done
);

  localparam int N  = BUFFER_WIDTH * BUFFER_HEIGHT;
  // A drain counter of zero width is not legal, so keep at least one bit.
  // With no drain stages the counter is never used.
  localparam int DW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  localparam logic [BUFFER_ADDR_WIDTH-1:0] ADDR_LAST  = BUFFER_ADDR_WIDTH'(N - 1);
  localparam logic [DW-1:0]                DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_CLEAR = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]                   state_q, state_d;
  logic [BUFFER_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DW-1:0]                drain_q, drain_d;

  // Next-state and counter update; the sweep stops on an exact match with the last address.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: begin
        if (clear_start) begin
          if (DRAIN_CYCLES == 0) begin
            state_d = S_CLEAR;
            addr_d  = '0;
          end else begin
            state_d = S_DRAIN;
            drain_d = '0;
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = S_CLEAR;
          addr_d  = '0;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      S_CLEAR: begin
        if (addr_q == ADDR_LAST) begin
          state_d = S_DONE;
        end else begin
          addr_d = addr_q + BUFFER_ADDR_WIDTH'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and counters; reset abandons any sweep in progress immediately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      drain_q <= drain_d;
    end
  end

  // Output decode from registered state only, except for the write gate.
  always_comb begin
    busy          = (state_q != S_IDLE);
    raster_stall  = busy;
    clear_req     = (state_q == S_CLEAR);
    clear_addr    = clear_req ? addr_q : '0;
    done          = (state_q == S_DONE);
    write_req_out = write_req_in & ~raster_stall;
  end

endmodule

// File: tb/tb_depth_clear_sequencer.sv
module tb_depth_clear_sequencer;

  localparam int SW  = 4;
  localparam int SH  = 2;
  localparam int SD  = 2;
  localparam int SN  = SW * SH;
  localparam int SAW = $clog2(SN);
  localparam int LN  = 160 * 120;
  localparam int LAW = $clog2(LN);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // small instance (4x2 buffer)
  logic           s_rstn, s_start, s_wr, s_wro, s_stall, s_cr, s_busy, s_done;
  logic [SAW-1:0] s_addr;
  // default-size instance (160x120 buffer)
  logic           l_rstn, l_start, l_wr, l_wro, l_stall, l_cr, l_busy, l_done;
  logic [LAW-1:0] l_addr;

  depth_clear_sequencer #(
    .BUFFER_WIDTH(SW), .BUFFER_HEIGHT(SH), .DRAIN_CYCLES(SD)
  ) u_small (
    .clk(clk), .rstn(s_rstn), .clear_start(s_start), .write_req_in(s_wr),
    .write_req_out(s_wro), .raster_stall(s_stall), .clear_req(s_cr),
    .clear_addr(s_addr), .busy(s_busy), .done(s_done)
  );

  depth_clear_sequencer u_large (
    .clk(clk), .rstn(l_rstn), .clear_start(l_start), .write_req_in(l_wr),
    .write_req_out(l_wro), .raster_stall(l_stall), .clear_req(l_cr),
    .clear_addr(l_addr), .busy(l_busy), .done(l_done)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: a sweep is identified by the cycle its start was accepted.
  // Outputs follow from the cycle offset since that start.
  int cyc = 0;
  int sweep_t = -1;

  task automatic model_cycle(input bit start, input bit wr, input bit rst);
    int  k;
    bit  m_busy, m_cr, m_done;
    int  m_addr;
    s_start = start;
    s_wr    = wr;
    s_rstn  = !rst;
    if (rst) sweep_t = -1;
    m_busy = 0; m_cr = 0; m_done = 0; m_addr = 0;
    if (sweep_t >= 0) begin
      k = cyc - sweep_t;
      if (k >= 1 && k <= SD + SN + 1) begin
        m_busy = 1;
        if (k >= SD + 1 && k <= SD + SN) begin
          m_cr   = 1;
          m_addr = k - SD - 1;
        end
        if (k == SD + SN + 1) m_done = 1;
      end
    end
    @(negedge clk);
    chk($sformatf("busy@%0d", cyc),   s_busy,  m_busy);
    chk($sformatf("stall@%0d", cyc),  s_stall, m_busy);
    chk($sformatf("clrreq@%0d", cyc), s_cr,    m_cr);
    chk($sformatf("addr@%0d", cyc),   s_addr,  m_addr);
    chk($sformatf("done@%0d", cyc),   s_done,  m_done);
    chk($sformatf("wro@%0d", cyc),    s_wro,   wr & !m_busy);
    if (!rst && !m_busy && start) sweep_t = cyc;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  typedef struct {
    bit       start;
    bit       wr;
    bit       busy;
    bit       cr;
    int       addr;
    bit       done;
    bit       wro;
  } vec_t;

  vec_t tbl[14];

  int s_done_cnt = 0;
  always @(negedge clk) if (s_done === 1'b1) s_done_cnt++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int first_c, last_c, last_a, strobes, done_c, done_n, busy_n, bad_seq;

    // start | wr | busy | clear_req | addr | done | write_req_out
    tbl[0]  = '{1, 1, 0, 0, 0, 0, 1};
    tbl[1]  = '{0, 1, 1, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 1, 0, 0, 0, 0};
    tbl[3]  = '{0, 1, 1, 1, 0, 0, 0};
    tbl[4]  = '{0, 1, 1, 1, 1, 0, 0};
    tbl[5]  = '{0, 1, 1, 1, 2, 0, 0};
    tbl[6]  = '{1, 1, 1, 1, 3, 0, 0};
    tbl[7]  = '{0, 1, 1, 1, 4, 0, 0};
    tbl[8]  = '{0, 1, 1, 1, 5, 0, 0};
    tbl[9]  = '{0, 1, 1, 1, 6, 0, 0};
    tbl[10] = '{0, 1, 1, 1, 7, 0, 0};
    tbl[11] = '{0, 1, 1, 0, 0, 1, 0};
    tbl[12] = '{0, 1, 0, 0, 0, 0, 1};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 0};

    s_rstn = 0; s_start = 0; s_wr = 0;
    l_rstn = 0; l_start = 0; l_wr = 0;
    @(posedge clk);
    #1;

    // reset held with start asserted: outputs idle, writes pass through
    for (int i = 0; i < 3; i++) model_cycle(1'b1, i[0], 1'b1);
    model_cycle(1'b0, 1'b1, 1'b0);
    model_cycle(1'b0, 1'b0, 1'b0);
    l_rstn = 1;

    // basic sweep from the vector table
    for (int i = 0; i < 14; i++) begin
      s_start = tbl[i].start;
      s_wr    = tbl[i].wr;
      @(negedge clk);
      chk($sformatf("tbl_busy[%0d]", i),  s_busy,  tbl[i].busy);
      chk($sformatf("tbl_stall[%0d]", i), s_stall, tbl[i].busy);
      chk($sformatf("tbl_cr[%0d]", i),    s_cr,    tbl[i].cr);
      chk($sformatf("tbl_addr[%0d]", i),  s_addr,  tbl[i].addr);
      chk($sformatf("tbl_done[%0d]", i),  s_done,  tbl[i].done);
      chk($sformatf("tbl_wro[%0d]", i),   s_wro,   tbl[i].wro);
      @(posedge clk);
      #1;
      cyc++;
    end
    sweep_t = -1;

    // start held high for 20 cycles: exactly two sweeps
    s_done_cnt = 0;
    for (int i = 0; i < 20; i++) model_cycle(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) model_cycle(1'b0, 1'b1, 1'b0);
    chk("held_start_done_count", s_done_cnt, 2);

    // asynchronous reset while clear_addr is 3, then restart from 0
    model_cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) model_cycle(1'b0, 1'b0, 1'b0);
    s_start = 0;
    @(negedge clk);
    chk("midrst_pre_addr", s_addr, 3);
    chk("midrst_pre_cr", s_cr, 1);
    #2 s_rstn = 0;
    #1;
    chk("midrst_cr", s_cr, 0);
    chk("midrst_busy", s_busy, 0);
    chk("midrst_stall", s_stall, 0);
    chk("midrst_addr", s_addr, 0);
    @(posedge clk);
    #1;
    cyc++;
    sweep_t = -1;
    model_cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) model_cycle(1'b0, 1'b1, 1'b0);

    // randomized starts, writes and occasional resets
    for (int i = 0; i < 600; i++) begin
      bit r_rst, r_start, r_wr;
      r_rst   = ($urandom_range(0, 99) < 2);
      r_start = ($urandom_range(0, 5) == 0);
      r_wr    = $urandom_range(0, 1) == 1;
      model_cycle(r_start, r_wr, r_rst);
    end
    s_start = 0;

    // full default-size sweep
    first_c = -1; last_c = -1; last_a = -1; strobes = 0;
    done_c = -1; done_n = 0; busy_n = 0; bad_seq = 0;
    l_start = 1;
    for (int c = 0; c < 19210; c++) begin
      @(negedge clk);
      if (l_cr === 1'b1) begin
        strobes++;
        if (first_c < 0) first_c = c;
        last_c = c;
        last_a = int'(l_addr);
        if (int'(l_addr) != c - 3) bad_seq++;
      end else if (l_addr !== '0) begin
        bad_seq++;
      end
      if (l_done === 1'b1) begin
        done_n++;
        done_c = c;
      end
      if (l_busy === 1'b1) busy_n++;
      @(posedge clk);
      #1;
      l_start = 0;
    end
    chk("big_first_strobe_cycle", first_c, 3);
    chk("big_last_strobe_cycle", last_c, 19202);
    chk("big_last_addr", last_a, 19199);
    chk("big_strobe_count", strobes, 19200);
    chk("big_done_cycle", done_c, 19203);
    chk("big_done_count", done_n, 1);
    chk("big_busy_cycles", busy_n, 19203);
    chk("big_addr_sequence_errors", bad_seq, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
